// File: rtl/vgac_param_if.sv
`default_nettype none
// ============================================================================
// Module   : vgac_param_if
// Purpose  : Bundle of the VGA controller's control, pixel-memory and video
//            signals.
//   master : controller side (drives addresses, read strobe, video outputs)
//   slave  : system side (drives enable, mode, memory data, solid colour)
// Signals  : en, mode[1:0], d_in_BGR/solid_BGR[3*CW], row_addr[RA],
//            col_addr[CA], read, r/g/b[CW], hs, vs, line_start, frame_start
// Revision : 1.0  initial release
// ============================================================================
interface vgac_param_if #(
   parameter int CW       = 4,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
);
   localparam int c_ra = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int c_ca = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

   logic                en;
   logic [1:0]          mode;
   logic [3*CW-1:0]     d_in_BGR;
   logic [3*CW-1:0]     solid_BGR;
   logic [c_ra-1:0]     row_addr;
   logic [c_ca-1:0]     col_addr;
   logic                read;
   logic [CW-1:0]       r;
   logic [CW-1:0]       g;
   logic [CW-1:0]       b;
   logic                hs;
   logic                vs;
   logic                line_start;
   logic                frame_start;

   modport master (
      input  en, mode, d_in_BGR, solid_BGR,
      output row_addr, col_addr, read, r, g, b, hs, vs, line_start, frame_start
   );

   modport slave (
      output en, mode, d_in_BGR, solid_BGR,
      input  row_addr, col_addr, read, r, g, b, hs, vs, line_start, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/vgac_param.sv
`default_nettype none
// ============================================================================
// Module   : vgac_param
// Purpose  : Parameterised VGA timing generator and pixel source mux.
//            Counter stage -> address stage (read/addresses/pulses) ->
//            RD_LAT-deep alignment pipe -> registered r/g/b, hs, vs.
// Ports    : vga_clk  pixel clock
//            clrn     asynchronous active-low reset
//            bus      vgac_param_if.master (en, mode, memory data, solid
//                     colour in; addresses, read, video and pulses out)
// Revision : 1.0  initial release
// ============================================================================
module vgac_param #(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 4,
   parameter int RD_LAT   = 1
) (
   input wire logic     vga_clk,
   input wire logic     clrn,
   vgac_param_if.master bus
);

   localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int c_hw      = $clog2(c_h_total);
   localparam int c_vw      = $clog2(c_v_total);
   localparam int c_ra      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int c_ca      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int c_bar_w   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int c_pw      = 6;   // {bar[2:0], vs, hs, visible}

   localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_total - 1);
   localparam logic [c_hw-1:0] c_h_vis_lo = c_hw'(H_SYNC + H_BP);
   localparam logic [c_hw-1:0] c_h_vis_hi = c_hw'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [c_hw-1:0] c_h_sync   = c_hw'(H_SYNC);
   localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_total - 1);
   localparam logic [c_vw-1:0] c_v_vis_lo = c_vw'(V_SYNC + V_BP);
   localparam logic [c_vw-1:0] c_v_vis_hi = c_vw'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [c_vw-1:0] c_v_sync   = c_vw'(V_SYNC);
   localparam logic [c_ca-1:0] c_bar_wl   = c_ca'(c_bar_w);
   localparam logic [c_ca-1:0] c_bar_max  = c_ca'(7);
   localparam logic [c_pw-1:0] c_tap_rst  = {3'b000, ~VS_POL, ~HS_POL, 1'b0};

   // ---------------------------------------------------------------- counters
   logic [c_hw-1:0] r_h_cnt;
   logic [c_vw-1:0] r_v_cnt;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (bus.en) begin
         if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            if (r_v_cnt == c_v_last) r_v_cnt <= '0;
            else                     r_v_cnt <= r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------- counter decode
   logic            w_vis;
   logic [c_ca-1:0] w_col;
   logic [c_ra-1:0] w_row;
   logic [c_ca-1:0] w_bar_q;
   logic [2:0]      w_bar;
   logic            w_hs_raw;
   logic            w_vs_raw;

   always_comb begin
      w_vis    = (r_h_cnt >= c_h_vis_lo) && (r_h_cnt <= c_h_vis_hi) &&
                 (r_v_cnt >= c_v_vis_lo) && (r_v_cnt <= c_v_vis_hi);
      w_col    = c_ca'(r_h_cnt - c_h_vis_lo);
      w_row    = c_ra'(r_v_cnt - c_v_vis_lo);
      // Columns past the eighth full bar (H_ACTIVE not a multiple of 8) stay black.
      w_bar_q  = w_col / c_bar_wl;
      w_bar    = (w_bar_q > c_bar_max) ? 3'd7 : w_bar_q[2:0];
      w_hs_raw = (r_h_cnt < c_h_sync) ? HS_POL : ~HS_POL;
      w_vs_raw = (r_v_cnt < c_v_sync) ? VS_POL : ~VS_POL;
   end

   // ----------------------------------------------------------- address stage
   logic            r_read;
   logic [c_ca-1:0] r_col_addr;
   logic [c_ra-1:0] r_row_addr;
   logic            r_line_start;
   logic            r_frame_start;
   logic            r_hs_a;
   logic            r_vs_a;
   logic [2:0]      r_bar_a;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_read        <= 1'b0;
         r_col_addr    <= '0;
         r_row_addr    <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_hs_a        <= ~HS_POL;
         r_vs_a        <= ~VS_POL;
         r_bar_a       <= 3'd0;
      end else if (bus.en) begin
         r_read        <= w_vis;
         r_col_addr    <= w_vis ? w_col : '0;
         r_row_addr    <= w_vis ? w_row : '0;
         r_line_start  <= (r_h_cnt == '0);
         r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
         r_hs_a        <= w_hs_raw;
         r_vs_a        <= w_vs_raw;
         r_bar_a       <= w_bar;
      end
   end

   // Mode is sampled at the end of the frame_start cycle, long before the
   // first visible pixel, so a whole frame always uses one source.
   logic [1:0] r_mode;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn)                            r_mode <= 2'b00;
      else if (bus.en && r_frame_start)     r_mode <= bus.mode;
   end

   // ------------------------------------------------ memory-latency alignment
   // Side-band (visible, syncs, bar index) is delayed RD_LAT clocks so it
   // sits next to the memory word that answers the same address.
   logic [c_pw-1:0] w_tap_a;
   logic [c_pw-1:0] w_tap_d;

   assign w_tap_a = {r_bar_a, r_vs_a, r_hs_a, r_read};

   generate
      if (RD_LAT == 0) begin : g_no_lat
         assign w_tap_d = w_tap_a;
      end else begin : g_lat
         logic [c_pw-1:0] r_pipe [RD_LAT];

         always_ff @(posedge vga_clk or negedge clrn) begin
            if (!clrn) begin
               for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= c_tap_rst;
            end else if (bus.en) begin
               r_pipe[0] <= w_tap_a;
               for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign w_tap_d = r_pipe[RD_LAT-1];
      end
   endgenerate

   // ------------------------------------------------------------ pixel source
   logic [2:0]      w_bar_mask;   // {b,g,r}
   logic [3*CW-1:0] w_bgr;

   always_comb begin
      case (w_tap_d[5:3])
         3'd0:    w_bar_mask = 3'b111;   // white
         3'd1:    w_bar_mask = 3'b011;   // yellow
         3'd2:    w_bar_mask = 3'b110;   // cyan
         3'd3:    w_bar_mask = 3'b010;   // green
         3'd4:    w_bar_mask = 3'b101;   // magenta
         3'd5:    w_bar_mask = 3'b001;   // red
         3'd6:    w_bar_mask = 3'b100;   // blue
         default: w_bar_mask = 3'b000;   // black
      endcase

      w_bgr = '0;
      if (w_tap_d[0]) begin
         case (r_mode)
            2'b00:   w_bgr = bus.d_in_BGR;
            2'b01:   w_bgr = {{CW{w_bar_mask[2]}}, {CW{w_bar_mask[1]}}, {CW{w_bar_mask[0]}}};
            2'b10:   w_bgr = bus.solid_BGR;
            default: w_bgr = '0;
         endcase
      end
   end

   // ------------------------------------------------------------ output stage
   logic [3*CW-1:0] r_bgr;
   logic            r_hs;
   logic            r_vs;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_bgr <= '0;
         r_hs  <= ~HS_POL;
         r_vs  <= ~VS_POL;
      end else if (bus.en) begin
         r_bgr <= w_bgr;
         r_hs  <= w_tap_d[1];
         r_vs  <= w_tap_d[2];
      end
   end

   assign bus.read        = r_read;
   assign bus.col_addr    = r_col_addr;
   assign bus.row_addr    = r_row_addr;
   assign bus.line_start  = r_line_start;
   assign bus.frame_start = r_frame_start;
   assign bus.r           = r_bgr[CW-1:0];
   assign bus.g           = r_bgr[2*CW-1:CW];
   assign bus.b           = r_bgr[3*CW-1:2*CW];
   assign bus.hs          = r_hs;
   assign bus.vs          = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vgac_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vgac_param
// Purpose  : Self-checking bench for vgac_param on a small raster.
//            The expected output of every clock is derived from the raster
//            position (count of enabled clocks since reset release) and
//            queued; an independent monitor pops and compares on the
//            falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_vgac_param;

   localparam int H_SYNC   = 4;
   localparam int H_BP     = 3;
   localparam int H_ACTIVE = 16;
   localparam int H_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 2;
   localparam int V_ACTIVE = 6;
   localparam int V_FP     = 1;
   localparam bit HS_POL   = 1'b1;
   localparam bit VS_POL   = 1'b0;
   localparam int CW       = 4;
   localparam int RD_LAT   = 2;

   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int F_TOTAL  = H_TOTAL * V_TOTAL;
   localparam int H0       = H_SYNC + H_BP;
   localparam int V0       = V_SYNC + V_BP;
   localparam int CA       = $clog2(H_ACTIVE);
   localparam int RA       = $clog2(V_ACTIVE);
   localparam int PW       = 3 * CW;
   localparam int N_CYC    = 3400;
   localparam int RST_AT   = 2300;
   localparam int FS_WAIT  = 64;

   typedef struct packed {
      logic          read;
      logic [CA-1:0] col;
      logic [RA-1:0] row;
      logic          ls;
      logic          fs;
      logic          hs;
      logic          vs;
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } exp_t;

   logic vga_clk = 1'b0;
   logic clrn    = 1'b0;

   vgac_param_if #(.CW(CW), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) bus ();

   vgac_param #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .RD_LAT(RD_LAT)
   ) dut (
      .vga_clk (vga_clk),
      .clrn    (clrn),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   // Reference state
   logic [PW-1:0] mem [V_ACTIVE][H_ACTIVE];
   logic [PW-1:0] solid;
   int            frame_mode [int];
   int            n;          // enabled clocks since reset release
   exp_t          sb_q [$];
   int            tests;
   int            fails;
   logic [2:0]    bar_bgr [8] = '{3'b111, 3'b011, 3'b110, 3'b010,
                                  3'b101, 3'b001, 3'b100, 3'b000};

   function automatic bit vis_of(int s);
      int h;
      int v;
      h = s % H_TOTAL;
      v = (s / H_TOTAL) % V_TOTAL;
      return (h >= H0) && (h < H0 + H_ACTIVE) && (v >= V0) && (v < V0 + V_ACTIVE);
   endfunction

   // Outputs after k enabled clocks: address-side items describe raster
   // position k-1, video-side items describe position k-2-RD_LAT.
   function automatic exp_t model(int k);
      exp_t          e;
      int            s1;
      int            s2;
      int            h;
      int            v;
      int            m;
      logic [2:0]    mask;
      logic [PW-1:0] w;
      e    = '0;
      e.hs = ~HS_POL;
      e.vs = ~VS_POL;
      s1   = k - 1;
      s2   = k - 2 - RD_LAT;
      if (s1 >= 0) begin
         h    = s1 % H_TOTAL;
         v    = (s1 / H_TOTAL) % V_TOTAL;
         e.ls = (h == 0);
         e.fs = (s1 % F_TOTAL == 0);
         if (vis_of(s1)) begin
            e.read = 1'b1;
            e.col  = CA'(h - H0);
            e.row  = RA'(v - V0);
         end
      end
      if (s2 >= 0) begin
         h    = s2 % H_TOTAL;
         v    = (s2 / H_TOTAL) % V_TOTAL;
         e.hs = (h < H_SYNC) ? HS_POL : ~HS_POL;
         e.vs = (v < V_SYNC) ? VS_POL : ~VS_POL;
         if (vis_of(s2)) begin
            m = frame_mode.exists(s2 / F_TOTAL) ? frame_mode[s2 / F_TOTAL] : 0;
            case (m)
               0: begin
                  w   = mem[v - V0][h - H0];
                  e.b = w[PW-1 -: CW];
                  e.g = w[2*CW-1 -: CW];
                  e.r = w[CW-1:0];
               end
               1: begin
                  mask = bar_bgr[(h - H0) / (H_ACTIVE / 8)];
                  e.b  = mask[2] ? {CW{1'b1}} : '0;
                  e.g  = mask[1] ? {CW{1'b1}} : '0;
                  e.r  = mask[0] ? {CW{1'b1}} : '0;
               end
               2: begin
                  e.b = solid[PW-1 -: CW];
                  e.g = solid[2*CW-1 -: CW];
                  e.r = solid[CW-1:0];
               end
               default: ;
            endcase
         end
      end
      return e;
   endfunction

   // Driver: advances the raster model, queues the expectation, and drives
   // the next cycle's inputs (memory answers from the model's own address).
   initial begin
      int   sd;
      logic [1:0] drv_mode;
      tests    = 0;
      fails    = 0;
      n        = 0;
      drv_mode = 2'b00;
      solid    = PW'($urandom);
      foreach (mem[i, j]) mem[i][j] = PW'($urandom);
      bus.en        = 1'b0;
      bus.mode      = 2'b00;
      bus.solid_BGR = solid;
      bus.d_in_BGR  = '0;

      for (int c = 0; c < N_CYC; c++) begin
         @(posedge vga_clk);
         if (clrn && bus.en) begin
            n++;
            if (n % F_TOTAL == 2) frame_mode[(n - 2) / F_TOTAL] = int'(bus.mode);
         end
         #1;
         if (c == 4) clrn = 1'b1;
         if (c == RST_AT) begin
            clrn = 1'b0;
            n    = 0;
            frame_mode.delete();
            #1;
            tests++;
            if (bus.read !== 1'b0 || bus.col_addr !== '0 || bus.row_addr !== '0 ||
                bus.line_start !== 1'b0 || bus.frame_start !== 1'b0 ||
                bus.hs !== ~HS_POL || bus.vs !== ~VS_POL ||
                bus.r !== '0 || bus.g !== '0 || bus.b !== '0) begin
               fails++;
               $display("FAIL reset state: read=%0b col=%0d row=%0d ls=%0b fs=%0b hs=%0b vs=%0b bgr=%h/%h/%h",
                        bus.read, bus.col_addr, bus.row_addr, bus.line_start, bus.frame_start,
                        bus.hs, bus.vs, bus.b, bus.g, bus.r);
            end
         end
         if (c == RST_AT + 3) clrn = 1'b1;
         sb_q.push_back(model(n));

         if (c < 1400)      bus.en = 1'b1;
         else if (c < 2000) bus.en = c[0];
         else               bus.en = ($urandom_range(0, 3) != 0);

         if (c < 1400)                            drv_mode = 2'(((c + 125) / F_TOTAL) % 4);
         else if ($urandom_range(0, 299) == 0)    drv_mode = 2'($urandom_range(0, 3));
         bus.mode = drv_mode;

         sd = n - 1 - RD_LAT;
         if (sd >= 0 && vis_of(sd))
            bus.d_in_BGR = mem[(sd / H_TOTAL) % V_TOTAL - V0][sd % H_TOTAL - H0];
         else
            bus.d_in_BGR = PW'($urandom);
      end

      @(negedge vga_clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog: frame_start must follow every reset release within a bound
   initial begin
      int k;
      forever begin
         @(posedge clrn);
         k = 0;
         while (bus.frame_start !== 1'b1 && k < FS_WAIT) begin
            @(negedge vga_clk);
            k++;
         end
         tests++;
         if (bus.frame_start !== 1'b1) begin
            fails++;
            $display("FAIL timeout: no frame_start within %0d clocks of reset release", FS_WAIT);
         end
      end
   end

   // Monitor
   initial begin
      exp_t e;
      exp_t got;
      int   cyc;
      cyc = 0;
      forever begin
         @(negedge vga_clk);
         cyc++;
         if (sb_q.size() != 0) begin
            e           = sb_q.pop_front();
            got.read    = bus.read;
            got.col     = bus.col_addr;
            got.row     = bus.row_addr;
            got.ls      = bus.line_start;
            got.fs      = bus.frame_start;
            got.hs      = bus.hs;
            got.vs      = bus.vs;
            got.r       = bus.r;
            got.g       = bus.g;
            got.b       = bus.b;
            tests++;
            if (got !== e) begin
               fails++;
               $display("FAIL outputs cyc=%0d: got read=%0b col=%0d row=%0d ls=%0b fs=%0b hs=%0b vs=%0b bgr=%h/%h/%h ; expected read=%0b col=%0d row=%0d ls=%0b fs=%0b hs=%0b vs=%0b bgr=%h/%h/%h",
                        cyc, got.read, got.col, got.row, got.ls, got.fs, got.hs, got.vs, got.b, got.g, got.r,
                        e.read, e.col, e.row, e.ls, e.fs, e.hs, e.vs, e.b, e.g, e.r);
            end
         end
      end
   end

endmodule
`default_nettype wire
